// File: rtl/snd_unit.sv
// snd_unit: four-voice square-wave generator with per-voice duration timers and a 6-bit mixer.
// Defining SND_NOISE_EN turns voice 3 into an LFSR noise channel (x^15 + x^14 + 1).
module snd_unit #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned SAMPLE_DIV = 1134
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        snd_wen,
    input  logic [1:0]  w_param,
    input  logic [10:0] w_index,
    input  logic [15:0] w_val,
    output logic [5:0]  sample,
    output logic        sample_stb,
    output logic [3:0]  active
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SampW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [SampW-1:0] SampLast = SampW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        ParHp   = 2'd0,
        ParVol  = 2'd1,
        ParDur  = 2'd2,
        ParCtrl = 2'd3
    } param_e;

    logic [15:0] hp_q  [4];
    logic [15:0] hp_d  [4];
    logic [3:0]  vol_q [4];
    logic [3:0]  vol_d [4];
    logic [15:0] dur_q [4];
    logic [15:0] dur_d [4];
    logic [15:0] pc_q  [4];
    logic [15:0] pc_d  [4];
    logic [3:0]  en_q, en_d;
    logic [3:0]  ph_q, ph_d;

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SampW-1:0] samp_cnt_q, samp_cnt_d;
    logic             tick;
    logic             samp_wrap;
    logic             wr_ok;

    logic [5:0] mix;
    logic [5:0] sample_q;
    logic       sample_stb_q;
    logic [3:0] active_q;

`ifdef SND_NOISE_EN
    logic [14:0] lfsr_q, lfsr_d;
    logic [14:0] lfsr_step;

    assign lfsr_step = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
`endif

    // Free-running prescalers
    always_comb begin
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
        samp_wrap  = (samp_cnt_q == SampLast);
        samp_cnt_d = samp_wrap ? '0 : samp_cnt_q + SampW'(1);
    end

    // Voice update: oscillator and duration timer first, then a write to the voice overrides them.
    always_comb begin
        wr_ok = snd_wen && (w_index[10:2] == 9'd0);
        en_d  = en_q;
        ph_d  = ph_q;
`ifdef SND_NOISE_EN
        lfsr_d = lfsr_q;
`endif
        for (int v = 0; v < 4; v++) begin
            hp_d[v]  = hp_q[v];
            vol_d[v] = vol_q[v];
            dur_d[v] = dur_q[v];
            pc_d[v]  = pc_q[v];

            if (en_q[v]) begin
                if (hp_q[v] == 16'd0) begin
                    ph_d[v] = 1'b0;
                end else if (pc_q[v] <= 16'd1) begin
                    pc_d[v] = hp_q[v];
                    ph_d[v] = ~ph_q[v];
`ifdef SND_NOISE_EN
                    if (v == 3) begin
                        lfsr_d  = lfsr_step;
                        ph_d[v] = lfsr_step[0];
                    end
`endif
                end else begin
                    pc_d[v] = pc_q[v] - 16'd1;
                end

                // dur == 0 means play forever
                if (tick && (dur_q[v] != 16'd0)) begin
                    if (dur_q[v] == 16'd1) begin
                        dur_d[v] = 16'd0;
                        en_d[v]  = 1'b0;
                    end else begin
                        dur_d[v] = dur_q[v] - 16'd1;
                    end
                end
            end

            if (wr_ok && (w_index[1:0] == 2'(v))) begin
                case (param_e'(w_param))
                    ParHp: begin
                        hp_d[v] = w_val;
                        pc_d[v] = w_val;
                        ph_d[v] = ph_q[v];
                    end
                    ParVol: begin
                        vol_d[v] = w_val[3:0];
                    end
                    ParDur: begin
                        dur_d[v] = w_val;
                        en_d[v]  = en_q[v];
                    end
                    default: begin
                        dur_d[v] = dur_q[v];
                        en_d[v]  = w_val[0];
                        ph_d[v]  = 1'b0;
                        pc_d[v]  = w_val[0] ? hp_q[v] : 16'd0;
`ifdef SND_NOISE_EN
                        if ((v == 3) && w_val[0]) begin
                            lfsr_d = 15'h0001;
                        end
`endif
                    end
                endcase
            end
        end
    end

    // Mixer: 4 x 15 max = 60, fits in 6 bits
    always_comb begin
        mix = 6'd0;
        for (int v = 0; v < 4; v++) begin
            if (en_q[v] && ph_q[v]) begin
                mix = mix + {2'b00, vol_q[v]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < 4; v++) begin
                hp_q[v]  <= '0;
                vol_q[v] <= '0;
                dur_q[v] <= '0;
                pc_q[v]  <= '0;
            end
            en_q         <= '0;
            ph_q         <= '0;
            tick_cnt_q   <= '0;
            samp_cnt_q   <= '0;
            sample_q     <= '0;
            sample_stb_q <= 1'b0;
            active_q     <= '0;
        end else begin
            for (int v = 0; v < 4; v++) begin
                hp_q[v]  <= hp_d[v];
                vol_q[v] <= vol_d[v];
                dur_q[v] <= dur_d[v];
                pc_q[v]  <= pc_d[v];
            end
            en_q         <= en_d;
            ph_q         <= ph_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            sample_q     <= mix;
            sample_stb_q <= samp_wrap;
            active_q     <= en_q;
        end
    end

`ifdef SND_NOISE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 15'h0001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign sample     = sample_q;
    assign sample_stb = sample_stb_q;
    assign active     = active_q;

endmodule

// File: tb/tb_snd_unit.sv
// tb_snd_unit: directed stimulus for snd_unit, checked every cycle against a behavioural voice
// model plus hand-computed expectations for tone timing, auto-stop, mixing and reset.
module tb_snd_unit;

    localparam int TB_TICK = 10;
    localparam int TB_SAMP = 7;

    logic        clk;
    logic        reset;
    logic        snd_wen;
    logic [1:0]  w_param;
    logic [10:0] w_index;
    logic [15:0] w_val;
    logic [5:0]  sample;
    logic        sample_stb;
    logic [3:0]  active;

    int n_cmp = 0;
    int n_bad = 0;

    snd_unit #(
        .TICK_DIV  (TB_TICK),
        .SAMPLE_DIV(TB_SAMP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .snd_wen   (snd_wen),
        .w_param   (w_param),
        .w_index   (w_index),
        .w_val     (w_val),
        .sample    (sample),
        .sample_stb(sample_stb),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_hp[4], m_vol[4], m_dur[4], m_pc[4];
    bit         m_en[4], m_ph[4];
    int         m_tcnt, m_scnt;
    int         m_lfsr;
    int         exp_sample;
    bit         exp_stb;
    logic [3:0] exp_active;

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_hp[v] = 0; m_vol[v] = 0; m_dur[v] = 0; m_pc[v] = 0;
            m_en[v] = 0; m_ph[v] = 0;
        end
        m_tcnt = 0; m_scnt = 0; m_lfsr = 1;
        exp_sample = 0; exp_stb = 0; exp_active = 4'h0;
    endtask

    task automatic model_step();
        int n_hp[4], n_vol[4], n_dur[4], n_pc[4];
        bit n_en[4], n_ph[4];
        bit tick, wrap;
        int sel, mix;
        tick = (m_tcnt == TB_TICK - 1);
        wrap = (m_scnt == TB_SAMP - 1);
        mix  = 0;
        for (int v = 0; v < 4; v++) begin
            if (m_en[v] && m_ph[v]) mix += m_vol[v];
            exp_active[v] = m_en[v];
        end
        exp_sample = mix;
        exp_stb    = wrap;
        m_tcnt = tick ? 0 : m_tcnt + 1;
        m_scnt = wrap ? 0 : m_scnt + 1;
        sel = (snd_wen === 1'b1 && w_index[10:2] == 9'd0) ? int'(w_index[1:0]) : -1;
        for (int v = 0; v < 4; v++) begin
            n_hp[v] = m_hp[v]; n_vol[v] = m_vol[v]; n_dur[v] = m_dur[v]; n_pc[v] = m_pc[v];
            n_en[v] = m_en[v]; n_ph[v] = m_ph[v];
            if (m_en[v]) begin
                if (m_hp[v] == 0) begin
                    n_ph[v] = 0;
                end else if (m_pc[v] <= 1) begin
                    n_pc[v] = m_hp[v];
                    n_ph[v] = !m_ph[v];
`ifdef SND_NOISE_EN
                    if (v == 3) begin
                        m_lfsr  = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7fff;
                        n_ph[v] = m_lfsr[0];
                    end
`endif
                end else begin
                    n_pc[v] = m_pc[v] - 1;
                end
                if (tick && m_dur[v] != 0 && !(sel == v && w_param >= 2'd2)) begin
                    n_dur[v] = m_dur[v] - 1;
                    if (n_dur[v] == 0) n_en[v] = 0;
                end
            end
            if (sel == v) begin
                case (w_param)
                    2'd0: begin n_hp[v] = w_val; n_pc[v] = w_val; n_ph[v] = m_ph[v]; end
                    2'd1: n_vol[v] = int'(w_val[3:0]);
                    2'd2: n_dur[v] = w_val;
                    default: begin
                        n_en[v] = w_val[0];
                        n_ph[v] = 0;
                        n_pc[v] = w_val[0] ? m_hp[v] : 0;
                        if (v == 3 && w_val[0]) m_lfsr = 1;
                    end
                endcase
            end
        end
        for (int v = 0; v < 4; v++) begin
            m_hp[v] = n_hp[v]; m_vol[v] = n_vol[v]; m_dur[v] = n_dur[v]; m_pc[v] = n_pc[v];
            m_en[v] = n_en[v]; m_ph[v] = n_ph[v];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model
    initial begin
        #2;
        forever begin
            @(negedge clk);
            check("model_sample", 32'(sample), 32'(exp_sample));
            check("model_stb", 32'(sample_stb), 32'(exp_stb));
            check("model_active", 32'(active), 32'(exp_active));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [1:0] p, input logic [10:0] idx, input logic [15:0] val);
        snd_wen = 1'b1; w_param = p; w_index = idx; w_val = val;
        @(posedge clk); #1;
        snd_wen = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n, mx;
    logic [3:0] act_any;

    initial begin
        reset = 1'b0; snd_wen = 1'b0; w_param = 2'd0; w_index = 11'd0; w_val = 16'd0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_sample", 32'(sample), 0);
        check("reset_stb", 32'(sample_stb), 0);
        check("reset_active", 32'(active), 0);

        // Voice 0 square wave, 4 cycles high / 4 low
        wr(2'd0, 11'd0, 16'd4);
        wr(2'd1, 11'd0, 16'd15);
        wr(2'd3, 11'd0, 16'd1);
        cyc(5);
        check("tone_first_high", 32'(sample), 15);
        check("tone_active", 32'(active), 32'h1);
        cyc(3);
        check("tone_high_end", 32'(sample), 15);
        cyc(1);
        check("tone_low", 32'(sample), 0);
        cyc(4);
        check("tone_second_high", 32'(sample), 15);

        n = 0;
        while (sample_stb !== 1'b1 && n < 20) begin cyc(1); n++; end
        check("stb_seen", 32'(sample_stb), 1);
        n = 0;
        do begin cyc(1); n++; end while (sample_stb !== 1'b1 && n < 20);
        check("stb_period", n, TB_SAMP);
        wr(2'd3, 11'd0, 16'd0);

        // Voice 1 auto-stop after 3 ticks
        wr(2'd0, 11'd1, 16'd2);
        wr(2'd1, 11'd1, 16'd3);
        wr(2'd2, 11'd1, 16'd3);
        wr(2'd3, 11'd1, 16'd1);
        cyc(1);
        check("dur_active_on", 32'(active), 32'h2);
        n = 1;
        while (active[1] !== 1'b0 && n < 40) begin cyc(1); n++; end
        check("dur_stop_in_time", 32'(n <= 31), 1);
        check("dur_stopped", 32'(active), 0);
        cyc(2);
        check("dur_silent", 32'(sample), 0);

        // All four voices in phase enough to peak at 60
        for (int v = 0; v < 4; v++) begin
            wr(2'd0, 11'(v), 16'd8);
            wr(2'd1, 11'(v), 16'd15);
            wr(2'd2, 11'(v), 16'd0);
        end
        for (int v = 0; v < 4; v++) wr(2'd3, 11'(v), 16'd1);
        mx = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (int'(sample) > mx) mx = int'(sample);
        end
        check("mix_peak", mx, 60);
        check("mix_active", 32'(active), 32'hf);
        for (int v = 0; v < 4; v++) wr(2'd3, 11'(v), 16'd0);

        // Out-of-range index writes are ignored
        wr(2'd0, 11'h004, 16'd2);
        wr(2'd3, 11'h004, 16'd1);
        wr(2'd3, 11'h405, 16'd1);
        cyc(3);
        check("ignored_no_enable", 32'(active), 0);
        wr(2'd3, 11'd0, 16'd1);
        cyc(10);
        check("ignored_hp_kept", 32'(sample), 15);
        wr(2'd3, 11'd0, 16'd0);

        // Duration write landing on a tick wins over the tick
        wr(2'd0, 11'd2, 16'd3);
        wr(2'd1, 11'd2, 16'd5);
        wr(2'd2, 11'd2, 16'd5);
        wr(2'd3, 11'd2, 16'd1);
        n = 0;
        while (m_tcnt != TB_TICK - 1 && n < 12) begin cyc(1); n++; end
        wr(2'd2, 11'd2, 16'd1);
        cyc(2);
        check("dur_tick_held", 32'(active), 32'h4);
        cyc(9);
        check("dur_tick_then_stop", 32'(active), 0);

        // Asynchronous reset while two voices sound
        wr(2'd0, 11'd0, 16'd4);
        wr(2'd1, 11'd0, 16'd15);
        wr(2'd0, 11'd1, 16'd6);
        wr(2'd1, 11'd1, 16'd7);
        wr(2'd3, 11'd0, 16'd1);
        wr(2'd3, 11'd1, 16'd1);
        n = 0;
        while (sample === 6'd0 && n < 20) begin cyc(1); n++; end
        check("pre_reset_sounding", 32'(sample != 6'd0), 1);
        #2 reset = 1'b1;
        #1;
        check("reset_async_sample", 32'(sample), 0);
        check("reset_async_active", 32'(active), 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        mx = 0;
        act_any = 4'h0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (int'(sample) > mx) mx = int'(sample);
            act_any = act_any | active;
        end
        check("post_reset_silent", mx, 0);
        check("post_reset_idle", 32'(act_any), 0);

`ifdef SND_NOISE_EN
        wr(2'd0, 11'd3, 16'd1);
        wr(2'd1, 11'd3, 16'd1);
        wr(2'd3, 11'd3, 16'd1);
        cyc(110);
        wr(2'd3, 11'd3, 16'd0);
`endif

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
